// File: rtl/running_min_tracker.sv
// Streaming frame reducer: reports minimum, first index of the minimum and beat count per frame.
// LogicalLT is the unsigned strict less-than comparator that decides every minimum update.

module LogicalLT #(
   parameter int    N     = 8,
   parameter string MODEL = "Structural"
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_lt
);

   generate
      if (MODEL == "Behavioral") begin : gBehav
         always_comb begin
            o_lt = (i_a < i_b);
         end
      end else if (MODEL == "DataFlow") begin : gFlow
         // Borrow of a-b rippling up from the LSB; a final borrow means a < b.
         logic [N:0] w_borrow;
         assign w_borrow[0] = 1'b0;
         for (genvar i = 0; i < N; i++) begin : gBit
            assign w_borrow[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_borrow[i]);
         end
         assign o_lt = w_borrow[N];
      end else begin : gStruct
         // Gate-level MSB-first scan: the first differing bit with a=0, b=1 decides.
         logic [N:1] w_eqAbove;
         logic [N:0] w_ltAcc;
         assign w_ltAcc[N] = 1'b0;
         for (genvar i = 0; i < N; i++) begin : gBit
            logic w_aN;
            logic w_bitLt;
            logic w_hit;
            logic w_eqIn;
            if (i == N-1) begin : gTop
               assign w_eqIn = 1'b1;
            end else begin : gInner
               assign w_eqIn = w_eqAbove[i+1];
            end
            not uNot (w_aN, i_a[i]);
            and uLt  (w_bitLt, w_aN, i_b[i]);
            and uHit (w_hit, w_bitLt, w_eqIn);
            or  uAcc (w_ltAcc[i], w_ltAcc[i+1], w_hit);
            if (i > 0) begin : gEq
               logic w_bitEq;
               xnor uEq  (w_bitEq, i_a[i], i_b[i]);
               and  uEqA (w_eqAbove[i], w_eqIn, w_bitEq);
            end
         end
         if (N > 1) begin : gTieTop
            assign w_eqAbove[N] = 1'b1;
         end else begin : gTieOne
            assign w_eqAbove[N] = w_ltAcc[N] | 1'b1;
         end
         assign o_lt = w_ltAcc[0];
      end
   endgenerate

endmodule


module running_min_tracker #(
   parameter int    N     = 8,
   parameter int    IDX_W = 8,
   parameter string MODEL = "Structural"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [N-1:0]     s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N-1:0]     m_min,
   output logic [IDX_W-1:0] m_idx,
   output logic [IDX_W-1:0] m_count,
   output logic             m_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

   state_t           r_state;
   logic             r_sReady;
   logic             r_mValid;
   logic [N-1:0]     r_min;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_cnt;
   logic             r_ovf;
   logic [N-1:0]     r_mMin;
   logic [IDX_W-1:0] r_mIdx;
   logic [IDX_W-1:0] r_mCount;
   logic             r_mOvf;

   logic             w_accept;
   logic             w_lt;
   logic             w_cntMax;
   logic [N-1:0]     w_nMin;
   logic [IDX_W-1:0] w_nIdx;
   logic [IDX_W-1:0] w_nCnt;
   logic             w_nOvf;

   LogicalLT #(.N(N), .MODEL(MODEL)) uLt (
      .i_a  (s_data),
      .i_b  (r_min),
      .o_lt (w_lt)
   );

   assign w_accept = s_valid & r_sReady;
   assign w_cntMax = (r_cnt == {IDX_W{1'b1}});

   // Frame state after accepting the current beat. The first beat loads without a
   // comparison; once the counter saturates, a new minimum records the saturated index.
   always_comb begin
      w_nMin = r_min;
      w_nIdx = r_idx;
      w_nCnt = r_cnt;
      w_nOvf = r_ovf;
      if (r_state == S_IDLE) begin
         w_nMin = s_data;
         w_nIdx = '0;
         w_nCnt = IDX_W'(1);
         w_nOvf = 1'b0;
      end else begin
         if (w_lt) begin
            w_nMin = s_data;
            w_nIdx = r_cnt;
         end
         if (w_cntMax) begin
            w_nOvf = 1'b1;
         end else begin
            w_nCnt = r_cnt + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sReady <= 1'b1;
         r_mValid <= 1'b0;
         r_min    <= '0;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_mMin   <= '0;
         r_mIdx   <= '0;
         r_mCount <= '0;
         r_mOvf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (w_accept) begin
                  r_min <= w_nMin;
                  r_idx <= w_nIdx;
                  r_cnt <= w_nCnt;
                  r_ovf <= w_nOvf;
                  if (s_last) begin
                     r_state  <= S_OUTPUT;
                     r_sReady <= 1'b0;
                     r_mValid <= 1'b1;
                     r_mMin   <= w_nMin;
                     r_mIdx   <= w_nIdx;
                     r_mCount <= w_nCnt;
                     r_mOvf   <= w_nOvf;
                  end else begin
                     r_state <= S_ACCUM;
                  end
               end
            end
            S_OUTPUT: begin
               if (m_ready) begin
                  r_state  <= S_IDLE;
                  r_sReady <= 1'b1;
                  r_mValid <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_sReady <= 1'b1;
               r_mValid <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready = r_sReady;
   assign m_valid = r_mValid;
   assign m_min   = r_mMin;
   assign m_idx   = r_mIdx;
   assign m_count = r_mCount;
   assign m_ovf   = r_mOvf;

endmodule
